alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU. Adds generic WIDTH, a 3-bit opcode with shifts, xor and a multi-cycle shift-add multiplier, registered results with status flags, and valid/ready flow control on both sides. It sits between an operand source such as a register file or sequencer and a result consumer, and processes one operation at a time.

---
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: one operation in flight, registered result and flags held until consumed.
// Optional shift-add multiplier for op 7 built only when ALU_SEQ_MUL_EN is defined; otherwise op 7 is flagged illegal.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             ovf_q, ovf_d, carry_q, carry_d, zero_q, zero_d;
    logic             ill_q, ill_d, out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   alu_c;
    logic               alu_ovf, alu_carry, alu_ill;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] shl_full;
    logic               b_big;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`endif

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shl_full  = {{WIDTH{1'b0}}, a} << b;
        b_big     = (b >= W_VAL);
        alu_c     = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        alu_ill   = 1'b0;
        case (op)
            3'd0: begin
                alu_c     = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                alu_c     = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: alu_c = a & b;
            3'd3: alu_c = a | b;
            3'd4: alu_c = a ^ b;
            3'd5: begin
                // Oversized shifts push every bit of a out.
                if (b_big) begin
                    alu_c   = '0;
                    alu_ovf = |a;
                end else begin
                    alu_c   = shl_full[WIDTH-1:0];
                    alu_ovf = |shl_full[2*WIDTH-1:WIDTH];
                end
            end
            3'd6: alu_c = b_big ? '0 : (a >> b);
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ill_d       = ill_q;
        out_valid_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == 3'd7) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = EXEC;
                    end else
`endif
                    begin
                        c_d     = alu_c;
                        ovf_d   = alu_ovf;
                        carry_d = alu_carry;
                        zero_d  = (alu_c == '0);
                        ill_d   = alu_ill;
                        state_d = DONE;
                    end
                end
            end
            EXEC: begin
`ifdef ALU_SEQ_MUL_EN
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    c_d     = acc_step[WIDTH-1:0];
                    ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
                    carry_d = 1'b0;
                    zero_d  = (acc_step[WIDTH-1:0] == '0);
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                // out_valid trails entry into DONE by one cycle; result is released on the handshake.
                out_valid_d = !(out_valid_q && out_ready);
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ill_q       <= ill_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign overflow  = ovf_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH = 8): arithmetic reference model plus a per-cycle monitor of handshake timing and results.
module tb_alu_seq;
    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b, c;
    logic [2:0] op;
    logic       in_valid, in_ready, overflow, carry, zero, illegal, out_valid, out_ready;
    logic [3:0] flags;

    always #5 clk = ~clk;
    assign flags = {illegal, zero, carry, overflow};

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .overflow(overflow), .carry(carry), .zero(zero), .illegal(illegal),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct packed {
        logic [7:0] c;
        logic [3:0] f;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
        int   lat;
    } item_t;

    item_t q[$];
    item_t mon_it;
    logic  mon_exp_ov;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic on plain integers; flags packed as {illegal, zero, carry, overflow}.
    function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
        int ua, ub, sa, sb, r;
        logic ovf, cy, ill;
        logic [7:0] cv;
        res_t res;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        ovf = 1'b0; cy = 1'b0; ill = 1'b0; cv = 8'd0;
        case (mop)
            3'd0: begin
                r = ua + ub;
                cv = 8'(r % 256);
                cy = (r > 255);
                ovf = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd1: begin
                r = ua - ub;
                cv = 8'((r + 256) % 256);
                cy = (ua < ub);
                ovf = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd2: cv = ma & mb;
            3'd3: cv = ma | mb;
            3'd4: cv = ma ^ mb;
            3'd5: begin
                if (ub >= 8) begin
                    cv = 8'd0;
                    ovf = (ua != 0);
                end else begin
                    r = ua * (1 << ub);
                    cv = 8'(r % 256);
                    ovf = (r > 255);
                end
            end
            3'd6: cv = (ub >= 8) ? 8'd0 : 8'(ua / (1 << ub));
            default: begin
`ifdef ALU_SEQ_MUL_EN
                r = ua * ub;
                cv = 8'(r % 256);
                ovf = (r > 255);
`else
                ill = 1'b1;
`endif
            end
        endcase
        res.c = cv;
        res.f = {ill, (cv == 8'd0), cy, ovf};
        return res;
    endfunction

    // Monitor: every negedge, compare handshake signals and (when valid) result against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_c", 32'(c), 32'd0);
                chk("rst_flags", 32'(flags), 32'd0);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                q.delete();
            end else begin
                chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
                mon_exp_ov = (q.size() > 0) && ((cyc - q[0].acc) > q[0].lat);
                chk("out_valid", 32'(out_valid), 32'(mon_exp_ov));
                if (mon_exp_ov && out_valid) begin
                    chk("c", 32'(c), 32'(q[0].r.c));
                    chk("flags", 32'(flags), 32'(q[0].r.f));
                    if (out_ready) void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    mon_it.r   = model(a, b, op);
                    mon_it.acc = cyc;
                    mon_it.lat = (op == 3'd7) ? MUL_LAT : 1;
                    q.push_back(mon_it);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                         input int hold, input bit lit, input logic [7:0] lc,
                         input logic [3:0] lf, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_in_ready_wait"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        n = 0;
        while (!out_valid && n < 30) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk({nm, "_out_valid_wait"}, 32'(out_valid), 32'd1);
        if (lit) begin
            chk({nm, "_c"}, 32'(c), 32'(lc));
            chk({nm, "_flags"}, 32'(flags), 32'(lf));
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        if (lit && hold > 0) begin
            chk({nm, "_hold_c"}, 32'(c), 32'(lc));
            chk({nm, "_hold_flags"}, 32'(flags), 32'(lf));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        issue(8'h7F, 8'h01, 3'd0, 0, 1'b1, 8'h80, 4'b0001, "add_7f_01");
        issue(8'h00, 8'h01, 3'd1, 0, 1'b1, 8'hFF, 4'b0010, "sub_00_01");
        issue(8'hFF, 8'h01, 3'd0, 0, 1'b1, 8'h00, 4'b0110, "add_ff_01");
        issue(8'h81, 8'h01, 3'd5, 5, 1'b1, 8'h02, 4'b0001, "shl_81_1");
        issue(8'h80, 8'h09, 3'd6, 0, 1'b1, 8'h00, 4'b0100, "shr_80_9");
        issue(8'hF0, 8'h3C, 3'd4, 1, 1'b1, 8'hCC, 4'b0000, "xor_f0_3c");
        issue(8'h01, 8'h08, 3'd5, 0, 1'b1, 8'h00, 4'b0101, "shl_01_8");
`ifdef ALU_SEQ_MUL_EN
        issue(8'h10, 8'h10, 3'd7, 2, 1'b1, 8'h00, 4'b0101, "mul_10_10");
        issue(8'h0F, 8'h11, 3'd7, 0, 1'b1, 8'hFF, 4'b0000, "mul_0f_11");
`else
        issue(8'h5A, 8'h3C, 3'd7, 0, 1'b1, 8'h00, 4'b1100, "op7_illegal");
`endif

        // Reset three cycles into an op 7 (EXEC with multiplier, DONE without).
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        a = 8'h12; b = 8'h34; op = 3'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        issue(8'h33, 8'h0F, 3'd2, 0, 1'b1, 8'h03, 4'b0000, "and_after_rst");

        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0, 8'h00, 4'h0, "rand");
        end

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
